// File: rtl/elastic_fifo.sv
// Circular elastic buffer of DEPTH entries; data pushed into an empty buffer is visible one cycle later.
// Backpressure: ready_in is !full from registered state only (no same-cycle push at full), and flush discards all entries.
module elastic_fifo #(
  parameter type T            = logic [31:0],
  parameter int  DEPTH        = 4,
  parameter int  AFULL_THRESH = DEPTH - 1,
  localparam int CW           = $clog2(DEPTH + 1),
  localparam int PW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          valid_in,
  output logic          ready_in,
  input  T              data_in,
  output logic          valid_out,
  input  logic          ready_out,
  output T              data_out,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign ready_in    = (count != CW'(DEPTH));
  assign valid_out   = (count != '0);
  assign data_out    = mem[rd_ptr];
  assign almost_full = (count >= CW'(AFULL_THRESH));

  assign push = valid_in & ready_in;
  assign pop  = valid_out & ready_out;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so data_out reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_elastic_fifo.sv
// Directed vector table plus multi-cycle sequences for elastic_fifo (DEPTH=4).
module tb_elastic_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] data_out;
  logic [2:0]  count;
  logic        almost_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elastic_fifo #(.T(logic [31:0]), .DEPTH(4), .AFULL_THRESH(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .count(count), .almost_full(almost_full)
  );

  typedef struct {
    logic        vi;
    logic [31:0] di;
    logic        ro;
    logic        evo;
    logic        eri;
    logic [31:0] edo;
    logic [2:0]  ecnt;
    logic        eaf;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(logic vi, logic [31:0] di, logic ro, logic evo,
                              logic eri, logic [31:0] edo, logic [2:0] ecnt, logic eaf);
    vec_t v;
    v.vi = vi; v.di = di; v.ro = ro; v.evo = evo;
    v.eri = eri; v.edo = edo; v.ecnt = ecnt; v.eaf = eaf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic vi, input logic [31:0] di, input logic ro);
    @(negedge clk);
    flush = fl; valid_in = vi; data_in = di; ready_out = ro;
    #1;
  endtask

  logic [31:0] sb[$];
  logic [31:0] next_item;
  logic [31:0] held;
  logic        was_stalled;
  int          sent;
  int          got;

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
    #1;
    chk("rst_vo",  {31'd0, valid_out},   32'd0);
    chk("rst_ri",  {31'd0, ready_in},    32'd1);
    chk("rst_do",  data_out,             32'd0);
    chk("rst_cnt", {29'd0, count},       32'd0);
    chk("rst_af",  {31'd0, almost_full}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill to full, refuse 0x104, then drain with pointer wrap.
    vt[0]  = mk(1, 32'h100, 0, 0, 1, 32'h000, 3'd0, 0);
    vt[1]  = mk(1, 32'h101, 0, 1, 1, 32'h100, 3'd1, 0);
    vt[2]  = mk(1, 32'h102, 0, 1, 1, 32'h100, 3'd2, 0);
    vt[3]  = mk(1, 32'h103, 0, 1, 1, 32'h100, 3'd3, 1);
    vt[4]  = mk(1, 32'h104, 0, 1, 0, 32'h100, 3'd4, 1);
    vt[5]  = mk(1, 32'h104, 0, 1, 0, 32'h100, 3'd4, 1);
    vt[6]  = mk(1, 32'h104, 1, 1, 0, 32'h100, 3'd4, 1);
    vt[7]  = mk(1, 32'h104, 1, 1, 1, 32'h101, 3'd3, 1);
    vt[8]  = mk(1, 32'h105, 1, 1, 1, 32'h102, 3'd3, 1);
    vt[9]  = mk(1, 32'h106, 1, 1, 1, 32'h103, 3'd3, 1);
    vt[10] = mk(1, 32'h107, 1, 1, 1, 32'h104, 3'd3, 1);
    vt[11] = mk(0, 32'h000, 1, 1, 1, 32'h105, 3'd3, 1);
    vt[12] = mk(0, 32'h000, 1, 1, 1, 32'h106, 3'd2, 0);
    vt[13] = mk(0, 32'h000, 1, 1, 1, 32'h107, 3'd1, 0);
    vt[14] = mk(0, 32'h000, 0, 0, 1, 32'h000, 3'd0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(1'b0, vt[i].vi, vt[i].di, vt[i].ro);
      chk($sformatf("vec%0d_vo", i),  {31'd0, valid_out},   {31'd0, vt[i].evo});
      chk($sformatf("vec%0d_ri", i),  {31'd0, ready_in},    {31'd0, vt[i].eri});
      chk($sformatf("vec%0d_cnt", i), {29'd0, count},       {29'd0, vt[i].ecnt});
      chk($sformatf("vec%0d_af", i),  {31'd0, almost_full}, {31'd0, vt[i].eaf});
      if (vt[i].evo) chk($sformatf("vec%0d_do", i), data_out, vt[i].edo);
    end

    // Streaming: one-cycle fill then one item per cycle at count 1.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(i), 1'b1);
      chk($sformatf("stream%0d_cnt", i), {29'd0, count}, (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk($sformatf("stream%0d_do", i), data_out, 32'h200 + 32'(i - 1));
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream_tail_do", data_out, 32'h213);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stream_empty_vo", {31'd0, valid_out}, 32'd0);

    // Random backpressure against an in-order scoreboard.
    next_item = 32'h0; sent = 0; got = 0; was_stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 5000 && got < 200; cyc++) begin
      drive(1'b0, (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0, next_item,
            1'($urandom_range(0, 1)));
      if (was_stalled) chk("bp_hold", data_out, held);
      if (valid_out && ready_out) begin
        if (sb.size() == 0) chk("bp_underflow", 32'd1, 32'd0);
        else chk("bp_order", data_out, sb.pop_front());
        got++;
      end
      if (valid_in && ready_in) begin
        sb.push_back(next_item);
        next_item++;
        sent++;
      end
      was_stalled = valid_out && !ready_out;
      held = data_out;
    end
    chk("bp_all_received", 32'(got), 32'd200);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp_final_cnt", {29'd0, count}, 32'd0);

    // Flush with simultaneous push and pop while holding three entries.
    drive(1'b0, 1'b1, 32'h301, 1'b0);
    drive(1'b0, 1'b1, 32'h302, 1'b0);
    drive(1'b0, 1'b1, 32'h303, 1'b0);
    drive(1'b1, 1'b1, 32'hBAD, 1'b1);
    chk("fl_pre_cnt", {29'd0, count},    32'd3);
    chk("fl_pre_vo",  {31'd0, valid_out}, 32'd1);
    chk("fl_pre_ri",  {31'd0, ready_in},  32'd1);
    drive(1'b0, 1'b1, 32'hA5, 1'b0);
    chk("fl_post_cnt", {29'd0, count},     32'd0);
    chk("fl_post_vo",  {31'd0, valid_out}, 32'd0);
    chk("fl_post_ri",  {31'd0, ready_in},  32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("fl_a5_vo",  {31'd0, valid_out}, 32'd1);
    chk("fl_a5_do",  data_out,           32'hA5);
    chk("fl_a5_cnt", {29'd0, count},     32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("fl_drained", {29'd0, count}, 32'd0);

    // Asynchronous reset mid-stream, between clock edges.
    drive(1'b0, 1'b1, 32'h11, 1'b0);
    drive(1'b0, 1'b1, 32'h22, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("ar_pre_cnt", {29'd0, count}, 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("ar_vo",  {31'd0, valid_out}, 32'd0);
    chk("ar_cnt", {29'd0, count},     32'd0);
    chk("ar_ri",  {31'd0, ready_in},  32'd1);
    chk("ar_do",  data_out,           32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h55, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("ar_55_vo",  {31'd0, valid_out}, 32'd1);
    chk("ar_55_do",  data_out,           32'h55);
    chk("ar_55_cnt", {29'd0, count},     32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
